led_blink_ctrl: RTL and testbench
=================================

Name: led_blink_ctrl

Overview:
Command-driven sequencer for the board LED.
- Owns the prescaler tick counter (count to TICK_MAX, same scheme as the existing counter/LED block) and a half-period phase counter.
- Decides per accepted command whether the LED is off, steady on, blinking continuously or emitting a counted burst.
- Sits between key/UART command logic and the LED pin.

Parameters:
TICK_MAX, 27'd24_999_999, tick period minus one in sys_clk cycles (250 ms at 100 MHz); must be < 2^27.
HALF_TICKS, 8'd2, ticks per LED half-period (on or off phase); legal range 1..255.

Ports:
sys_clk    input   1  system clock, 100 MHz
sys_rst_n  input   1  asynchronous active-low reset
cmd_valid  input   1  command present
cmd_ready  output  1  block can accept a command
cmd_mode   input   2  0=OFF, 1=STEADY, 2=BLINK, 3=BURST
cmd_count  input   4  number of blinks for BURST (0..15); ignored otherwise
led_out    output  1  LED drive, 1=on
busy       output  1  high while in BURST
done       output  1  one-cycle pulse when a BURST completes

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst_n is asynchronous and active-low; all flops clear immediately on assertion.
- Reset values: state=IDLE, tick_cnt=0, phase_cnt=0, remain=0, led_out=0, busy=0, done=0, cmd_ready=1.
- Reset mid-burst aborts the burst; no done pulse is generated.
- States: IDLE, STEADY, BLINK, BURST.
- cmd_ready is 1 in IDLE, STEADY and BLINK, and 0 in BURST. A BURST cannot be preempted; other modes can be.
- Accept: cmd_valid & cmd_ready at a rising edge. cmd_mode and cmd_count are sampled at that edge. tick_cnt and phase_cnt clear to 0 at the same edge.
- Registered outputs after accept, visible the following cycle:
  - OFF: state=IDLE, led_out=0.
  - STEADY: state=STEADY, led_out=1.
  - BLINK: state=BLINK, led_out=1 (on phase first).
  - BURST with cmd_count>0: state=BURST, led_out=1, busy=1, remain=cmd_count.
  - BURST with cmd_count=0: state=IDLE, led_out=0, done=1 for exactly one cycle, busy stays 0.
- Tick generation:
  - tick_cnt increments every cycle in BLINK and BURST and holds 0 in IDLE and STEADY.
  - At TICK_MAX it wraps to 0 and asserts the internal tick for that cycle.
- Phase counting:
  - On each tick, phase_cnt increments.
  - When phase_cnt==HALF_TICKS-1 on a tick, phase_cnt wraps to 0 and a phase boundary occurs.
  - Each half-period is therefore HALF_TICKS*(TICK_MAX+1) cycles.
- BLINK: led_out toggles at every phase boundary, indefinitely.
- BURST:
  - On-phase boundary: led_out becomes 0.
  - Off-phase boundary: remain decrements.
    - If remain was 1: state=IDLE, busy=0, done=1 for one cycle, led_out stays 0, cmd_ready=1 from the next cycle.
    - Otherwise: led_out becomes 1.
- Preemption: a new command accepted in BLINK or STEADY restarts timing from zero. There is no glitch beyond the registered update.
- Arithmetic: tick_cnt is 27 bits unsigned; phase_cnt is 8 bits; remain is 4 bits. No counter wraps except at the defined terminal values.
- cmd_valid while cmd_ready=0 is ignored. The source must hold cmd_valid until accepted.

Test Plan:
Sim parameters: TICK_MAX=4, HALF_TICKS=2 (half-period = 10 cycles).
1. Reset release at 20 ns, no commands -> led_out=0, cmd_ready=1, busy=0 and done=0 for 200 cycles.
2. BLINK accepted at cycle 10 -> led_out=1 on cycles 11-20, 0 on 21-30, 1 on 31-40; continuous 20-cycle period; cmd_ready stays 1.
3. BURST with cmd_count=3 accepted at cycle 10:
   - busy=1 and cmd_ready=0 on cycles 11-70.
   - led_out high on cycles 11-20, 31-40, 51-60 and low otherwise.
   - done=1 only on cycle 71; busy=0 and cmd_ready=1 from cycle 71.
   - A STEADY command held valid during the burst is accepted only at cycle 71, giving led_out=1 from cycle 72.
4. BURST with cmd_count=0 -> done pulses one cycle after accept, led_out stays 0, busy never asserts.
5. Blink in its off phase, then STEADY accepted -> led_out=1 next cycle and stays 1 for 100 cycles; then OFF -> led_out=0 next cycle.
6. sys_rst_n asserted asynchronously (mid-cycle) at cycle 35 of a 3-blink burst -> all outputs go to reset values immediately, with no done pulse; after release a new BURST with cmd_count=1 runs 20 cycles, then done.

Source files
------------

// File: rtl/led_blink_ctrl.sv
// Command-driven LED sequencer: off, steady, continuous blink or counted burst,
// timed by a TICK_MAX prescaler and a HALF_TICKS half-period phase counter.
module led_blink_ctrl #(
    parameter logic [26:0] TICK_MAX   = 27'd24_999_999,
    parameter logic [7:0]  HALF_TICKS = 8'd2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_count,
    output logic       led_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEADY = 2'd1,
        BLINK  = 2'd2,
        BURST  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_STEADY = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;
    localparam logic [1:0] MODE_BURST  = 2'd3;

    state_t      state_r, state_nxt_s;
    logic [26:0] tick_cnt_r, tick_cnt_nxt_s;
    logic [7:0]  phase_cnt_r, phase_cnt_nxt_s;
    logic [3:0]  remain_r, remain_nxt_s;
    logic        led_out_r, led_out_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        done_r, done_nxt_s;
    logic        ready_r, ready_nxt_s;
    logic        accept_s, timing_s, tick_s, boundary_s, burst_end_s;

    assign accept_s    = cmd_valid & ready_r;
    assign timing_s    = (state_r == BLINK) || (state_r == BURST);
    assign tick_s      = timing_s && (tick_cnt_r == TICK_MAX);
    assign boundary_s  = tick_s && (phase_cnt_r == (HALF_TICKS - 8'd1));
    // A burst ends on the off-phase boundary of its last blink
    assign burst_end_s = (state_r == BURST) && boundary_s && !led_out_r && (remain_r == 4'd1);

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r     <= IDLE;
            tick_cnt_r  <= 27'd0;
            phase_cnt_r <= 8'd0;
            remain_r    <= 4'd0;
            led_out_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            tick_cnt_r  <= tick_cnt_nxt_s;
            phase_cnt_r <= phase_cnt_nxt_s;
            remain_r    <= remain_nxt_s;
            led_out_r   <= led_out_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            ready_r     <= ready_nxt_s;
        end
    end

    // Next-state selection
    always_comb begin
        state_nxt_s = state_r;
        if (accept_s) begin
            case (cmd_mode)
                MODE_OFF:    state_nxt_s = IDLE;
                MODE_STEADY: state_nxt_s = STEADY;
                MODE_BLINK:  state_nxt_s = BLINK;
                MODE_BURST:  state_nxt_s = (cmd_count != 4'd0) ? BURST : IDLE;
                default:     state_nxt_s = IDLE;
            endcase
        end else if (burst_end_s) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Counters and registered output values
    always_comb begin
        tick_cnt_nxt_s  = 27'd0;
        phase_cnt_nxt_s = 8'd0;
        remain_nxt_s    = remain_r;
        led_out_nxt_s   = led_out_r;
        busy_nxt_s      = busy_r;
        done_nxt_s      = 1'b0;
        ready_nxt_s     = (state_nxt_s != BURST);
        if (accept_s) begin
            led_out_nxt_s = (cmd_mode != MODE_OFF) &&
                            !((cmd_mode == MODE_BURST) && (cmd_count == 4'd0));
            busy_nxt_s    = (cmd_mode == MODE_BURST) && (cmd_count != 4'd0);
            done_nxt_s    = (cmd_mode == MODE_BURST) && (cmd_count == 4'd0);
            remain_nxt_s  = (cmd_mode == MODE_BURST) ? cmd_count : 4'd0;
        end else if (timing_s) begin
            tick_cnt_nxt_s  = tick_s ? 27'd0 : (tick_cnt_r + 27'd1);
            phase_cnt_nxt_s = boundary_s ? 8'd0 :
                              (tick_s ? (phase_cnt_r + 8'd1) : phase_cnt_r);
            if (boundary_s && (state_r == BLINK)) begin
                led_out_nxt_s = !led_out_r;
            end else if (boundary_s && led_out_r) begin
                led_out_nxt_s = 1'b0;
            end else if (boundary_s) begin
                remain_nxt_s = remain_r - 4'd1;
                if (remain_r == 4'd1) begin
                    busy_nxt_s    = 1'b0;
                    done_nxt_s    = 1'b1;
                    led_out_nxt_s = 1'b0;
                end else begin
                    led_out_nxt_s = 1'b1;
                end
            end else begin
                led_out_nxt_s = led_out_r;
            end
        end else begin
            tick_cnt_nxt_s  = 27'd0;
            phase_cnt_nxt_s = 8'd0;
        end
    end

    assign cmd_ready = ready_r;
    assign led_out   = led_out_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Scoreboard bench for led_blink_ctrl: a time-since-accept reference model queues
// the expected outputs per cycle, a monitor pops and compares them.
module tb_led_blink_ctrl;

    localparam int TM = 4;
    localparam int HT = 2;
    localparam int HP = HT * (TM + 1);

    logic       sys_clk;
    logic       sys_rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_count;
    logic       led_out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];
    int         mode_m, count_m, t_m;
    logic       ready_m;

    led_blink_ctrl #(.TICK_MAX(27'd4), .HALF_TICKS(8'd2)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_count(cmd_count),
        .led_out(led_out), .busy(busy), .done(done)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Expected {led_out, cmd_ready, busy, done} from mode, count and cycles since accept
    function automatic logic [3:0] expect_out(int m, int c, int t);
        int l;
        l = 2 * c * HP;
        case (m)
            1: return 4'b1100;
            2: return {((t / HP) % 2 == 0), 3'b100};
            3: begin
                if (t < l) return {((t / HP) % 2 == 0), 3'b010};
                else if (t == l) return 4'b0101;
                else return 4'b0100;
            end
            4: return (t == 0) ? 4'b0101 : 4'b0100;
            default: return 4'b0100;
        endcase
    endfunction

    // Reference model: pushes the expectation for the cycle after each edge
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_m  = 0;
            count_m = 0;
            t_m     = 0;
            ready_m = 1'b1;
            exp_q.delete();
        end else begin
            logic [3:0] e;
            if (cmd_valid && ready_m) begin
                mode_m  = (cmd_mode == 2'd3 && cmd_count == 4'd0) ? 4 : int'(cmd_mode);
                count_m = int'(cmd_count);
                t_m     = 0;
            end else begin
                t_m = t_m + 1;
            end
            e = expect_out(mode_m, count_m, t_m);
            ready_m = e[2];
            exp_q.push_back(e);
        end
    end

    // Monitor: compares DUT outputs against reset values or the queued expectation
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            checks++;
            if ({led_out, cmd_ready, busy, done} !== 4'b0100) begin
                errors++;
                $display("FAIL reset_outputs t=%0t got=%b expected=0100", $time,
                         {led_out, cmd_ready, busy, done});
            end
        end else if (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({led_out, cmd_ready, busy, done} !== e) begin
                errors++;
                $display("FAIL outputs{led,ready,busy,done} t=%0t got=%b expected=%b",
                         $time, {led_out, cmd_ready, busy, done}, e);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Hold a command valid until the handshake completes, with a bounded wait
    task automatic send(input logic [1:0] m, input logic [3:0] c);
        logic ok;
        @(negedge sys_clk);
        cmd_mode  = m;
        cmd_count = c;
        cmd_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            ok = cmd_ready;
            @(posedge sys_clk);
            #1;
            if (ok) begin
                cmd_valid = 1'b0;
                return;
            end
            @(negedge sys_clk);
        end
        checks++;
        errors++;
        cmd_valid = 1'b0;
        $display("FAIL accept_timeout mode=%0d got=no_accept expected=accept", m);
    endtask

    task automatic async_reset();
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({led_out, cmd_ready, busy, done} !== 4'b0100) begin
            errors++;
            $display("FAIL async_reset_immediate got=%b expected=0100",
                     {led_out, cmd_ready, busy, done});
        end
        idle(3);
        #2;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_count = 4'd0;
        #20 sys_rst_n = 1'b1;

        idle(200);
        send(2'd2, 4'd0);
        idle(50);
        send(2'd0, 4'd0);
        idle(5);
        send(2'd3, 4'd3);
        send(2'd1, 4'd0);
        idle(10);
        send(2'd0, 4'd0);
        send(2'd3, 4'd0);
        idle(10);
        send(2'd2, 4'd0);
        idle(15);
        send(2'd1, 4'd0);
        idle(100);
        send(2'd0, 4'd0);
        idle(5);
        send(2'd3, 4'd3);
        idle(24);
        async_reset();
        idle(2);
        send(2'd3, 4'd1);
        idle(30);

        for (int k = 0; k < 40; k++) begin
            send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 4)));
            idle($urandom_range(0, 50));
            if (k == 20) async_reset();
        end
        send(2'd3, 4'd15);
        idle(310);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
